// File: rtl/cordic_iter_unit.sv
// rtl/cordic_iter_unit.sv - folded CORDIC engine, rotation/vectoring with range reduction and gain compensation
module cordic_iter_unit #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_WIDTH = 8,
   parameter int WORK_WIDTH = 32,
   parameter int WORK_FRAC  = 20,
   parameter int ITER_NUM   = 12,
   parameter int CNT_WIDTH  = 4,
   parameter int GAIN_COMP  = 636751
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  mode,
   input  logic [DATA_WIDTH-1:0] x_in,
   input  logic [DATA_WIDTH-1:0] y_in,
   input  logic [DATA_WIDTH-1:0] angle_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] x_out,
   output logic [DATA_WIDTH-1:0] y_out,
   output logic [DATA_WIDTH-1:0] angle_out,
   output logic                  sat_out,
   output logic                  err_out
);

   localparam int SH_IN = WORK_FRAC - FRAC_WIDTH;
   localparam int PW    = 2 * WORK_WIDTH;

   // pi is derived from its 30-fraction-bit constant so it tracks WORK_FRAC
   localparam logic signed [WORK_WIDTH-1:0] PI_W =
      WORK_WIDTH'((64'd3373259426 + (64'd1 << (29 - WORK_FRAC))) >> (30 - WORK_FRAC));
   localparam logic signed [WORK_WIDTH-1:0] HALF_PI  = PI_W >>> 1;
   localparam logic signed [PW-1:0]         GAIN_P   = PW'(GAIN_COMP);
   localparam logic signed [PW-1:0]         RND_HALF = PW'(1) <<< (SH_IN - 1);
   localparam logic signed [PW-1:0]         MAX_O    = (PW'(1) <<< (DATA_WIDTH - 1)) - PW'(1);
   localparam logic signed [PW-1:0]         MIN_O    = ~MAX_O;

   typedef enum logic [2:0] {IDLE, PRE, ITER, POST, HOLD} state_t;

   state_t                         state;
   logic [CNT_WIDTH-1:0]           cnt;
   logic                           mode_r;
   logic                           err_r;
   logic signed [WORK_WIDTH-1:0]   x_r, y_r, z_r;
   logic [DATA_WIDTH-1:0]          ang_r;

   logic signed [WORK_WIDTH-1:0]   atan_w, x_sh, y_sh, x_nx, y_nx, z_nx;
   logic                           d_pos;
   logic signed [PW-1:0]           gx, gy, zq;
   logic [DATA_WIDTH:0]            cx, cy, cz;

   // atan(2^-i) with 20 fraction bits (the default WORK_FRAC)
   function automatic int atan_q20(input int i);
      case (i)
         0:  return 823550;
         1:  return 486170;
         2:  return 256879;
         3:  return 130396;
         4:  return 65451;
         5:  return 32757;
         6:  return 16383;
         7:  return 8192;
         8:  return 4096;
         9:  return 2048;
         10: return 1024;
         11: return 512;
         12: return 256;
         13: return 128;
         14: return 64;
         15: return 32;
         16: return 16;
         17: return 8;
         18: return 4;
         19: return 2;
         default: return 0;
      endcase
   endfunction

   function automatic logic signed [PW-1:0] rnd(input logic signed [PW-1:0] v);
      return (v + RND_HALF) >>> SH_IN;
   endfunction

   // returns {clipped, value}
   function automatic logic [DATA_WIDTH:0] clip(input logic signed [PW-1:0] v);
      if (v > MAX_O)
         return {1'b1, MAX_O[DATA_WIDTH-1:0]};
      else if (v < MIN_O)
         return {1'b1, MIN_O[DATA_WIDTH-1:0]};
      else
         return {1'b0, v[DATA_WIDTH-1:0]};
   endfunction

   assign atan_w = WORK_WIDTH'(atan_q20(32'(cnt)));

   always_comb begin
      x_sh  = x_r >>> cnt;
      y_sh  = y_r >>> cnt;
      d_pos = mode_r ? y_r[WORK_WIDTH-1] : !z_r[WORK_WIDTH-1];
      if (d_pos) begin
         x_nx = x_r - y_sh;
         y_nx = y_r + x_sh;
         z_nx = z_r - atan_w;
      end else begin
         x_nx = x_r + y_sh;
         y_nx = y_r - x_sh;
         z_nx = z_r + atan_w;
      end
   end

   always_comb begin
      gx = rnd((PW'(x_r) * GAIN_P) >>> WORK_FRAC);
      gy = rnd((PW'(y_r) * GAIN_P) >>> WORK_FRAC);
      zq = rnd(PW'(z_r));
      cx = clip(gx);
      cy = clip(gy);
      cz = clip(zq);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         mode_r    <= 1'b0;
         err_r     <= 1'b0;
         x_r       <= '0;
         y_r       <= '0;
         z_r       <= '0;
         ang_r     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         x_out     <= '0;
         y_out     <= '0;
         angle_out <= '0;
         sat_out   <= 1'b0;
         err_out   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  mode_r   <= mode;
                  err_r    <= 1'b0;
                  ang_r    <= angle_in;
                  x_r      <= WORK_WIDTH'($signed(x_in)) <<< SH_IN;
                  y_r      <= WORK_WIDTH'($signed(y_in)) <<< SH_IN;
                  z_r      <= mode ? '0 : (WORK_WIDTH'($signed(angle_in)) <<< SH_IN);
                  in_ready <= 1'b0;
                  state    <= PRE;
               end
            end
            PRE: begin
               cnt   <= '0;
               state <= ITER;
               if (!mode_r) begin
                  if (z_r > PI_W || z_r < -PI_W) begin
                     err_r <= 1'b1;
                     x_r   <= '0;
                     y_r   <= '0;
                     z_r   <= '0;
                  end else if (z_r > HALF_PI) begin
                     z_r <= z_r - PI_W;
                     x_r <= -x_r;
                     y_r <= -y_r;
                  end else if (z_r < -HALF_PI) begin
                     z_r <= z_r + PI_W;
                     x_r <= -x_r;
                     y_r <= -y_r;
                  end
               end else if (x_r[WORK_WIDTH-1]) begin
                  // rotate by pi into the right half-plane and pre-load the angle
                  x_r <= -x_r;
                  y_r <= -y_r;
                  z_r <= y_r[WORK_WIDTH-1] ? -PI_W : PI_W;
               end else begin
                  z_r <= '0;
               end
            end
            ITER: begin
               x_r <= x_nx;
               y_r <= y_nx;
               z_r <= z_nx;
               if (cnt == CNT_WIDTH'(ITER_NUM - 1))
                  state <= POST;
               else
                  cnt <= cnt + 1'b1;
            end
            POST: begin
               x_out     <= cx[DATA_WIDTH-1:0];
               y_out     <= cy[DATA_WIDTH-1:0];
               angle_out <= mode_r ? cz[DATA_WIDTH-1:0] : ang_r;
               sat_out   <= cx[DATA_WIDTH] | cy[DATA_WIDTH] | (mode_r & cz[DATA_WIDTH]);
               err_out   <= err_r;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_iter_unit.sv
// tb/tb_cordic_iter_unit.sv - scoreboard bench for cordic_iter_unit with directed vectors
module tb_cordic_iter_unit;

   localparam int ITER_NUM = 12;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, mode, out_valid, out_ready, sat_out, err_out;
   logic [15:0] x_in, y_in, angle_in, x_out, y_out, angle_out;

   always #5 clk = ~clk;

   cordic_iter_unit dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
      .x_in(x_in), .y_in(y_in), .angle_in(angle_in), .out_valid(out_valid), .out_ready(out_ready),
      .x_out(x_out), .y_out(y_out), .angle_out(angle_out), .sat_out(sat_out), .err_out(err_out)
   );

   typedef struct {
      int          tag;
      logic [15:0] x, y, a;
      int          tx, ty, ta;
      logic        sat, err;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   fails  = 0;
   time  t_acc;

   task automatic chk_val(input string nm, input int tag, input logic [15:0] act,
                          input logic [15:0] want, input int tol);
      int d;
      d = int'($signed(act)) - int'($signed(want));
      checks++;
      if (d > tol || d < -tol) begin
         fails++;
         $display("FAIL %s[op %0d]: got 0x%04h, want 0x%04h +/-%0d", nm, tag, act, want, tol);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int want);
      checks++;
      if (act != want) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", nm, act, want);
      end
   endtask

   task automatic expect_op(input int tag, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] a, input int tx, input int ty, input int ta,
                            input logic s, input logic e);
      exp_t r;
      r.tag = tag; r.x = x; r.y = y; r.a = a;
      r.tx = tx; r.ty = ty; r.ta = ta; r.sat = s; r.err = e;
      sb.push_back(r);
   endtask

   task automatic send(input logic m, input logic [15:0] xi, input logic [15:0] yi,
                       input logic [15:0] ai);
      int n = 0;
      @(posedge clk); #1;
      mode = m; x_in = xi; y_in = yi; angle_in = ai; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk_int("accept_in_ready", int'(in_ready), 1);
      @(posedge clk);
      t_acc = $time;
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk_int("drain_pending", sb.size(), 0);
      @(posedge clk); #1;
   endtask

   // monitor: compare on every output handshake
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_output: out_valid=1 x_out=0x%04h, want no output", x_out);
         end else begin
            mon_e = sb.pop_front();
            chk_val("x_out", mon_e.tag, x_out, mon_e.x, mon_e.tx);
            chk_val("y_out", mon_e.tag, y_out, mon_e.y, mon_e.ty);
            chk_val("angle_out", mon_e.tag, angle_out, mon_e.a, mon_e.ta);
            chk_val("sat_out", mon_e.tag, {15'd0, sat_out}, {15'd0, mon_e.sat}, 0);
            chk_val("err_out", mon_e.tag, {15'd0, err_out}, {15'd0, mon_e.err}, 0);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat, nval;
      time  t1;
      logic [15:0] hx, hy, ha;

      reset = 1'b1; in_valid = 1'b0; mode = 1'b0;
      x_in = '0; y_in = '0; angle_in = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_int("reset_in_ready", int'(in_ready), 1);
      chk_int("reset_out_valid", int'(out_valid), 0);
      chk_int("reset_outputs", int'({x_out, y_out, angle_out, sat_out, err_out}), 0);
      @(negedge clk) reset = 1'b0;

      // rotation pi/4, vectoring pi/3, range folding, error, saturation, third quadrant
      expect_op(1, 16'h00B5, 16'h00B5, 16'h00C9, 1, 1, 0, 1'b0, 1'b0);
      send(1'b0, 16'h0100, 16'h0000, 16'h00C9);
      expect_op(2, 16'h0200, 16'h0000, 16'h010C, 2, 2, 1, 1'b0, 1'b0);
      send(1'b1, 16'h0100, 16'h01BB, 16'h0000);
      expect_op(3, 16'hFF00, 16'h0000, 16'h0324, 1, 1, 0, 1'b0, 1'b0);
      send(1'b0, 16'h0100, 16'h0000, 16'h0324);
      expect_op(4, 16'h0100, 16'h0000, 16'h0324, 2, 2, 1, 1'b0, 1'b0);
      send(1'b1, 16'hFF00, 16'h0000, 16'h0000);
      expect_op(5, 16'h0000, 16'h0000, 16'h0400, 0, 0, 0, 1'b0, 1'b1);
      send(1'b0, 16'h0100, 16'h0000, 16'h0400);
      expect_op(6, 16'h7FFF, 16'h0000, 16'h00C9, 0, 48, 1, 1'b1, 1'b0);
      send(1'b1, 16'h7F00, 16'h7F00, 16'h0000);
      expect_op(7, 16'h016A, 16'h0000, 16'hFDA5, 2, 2, 1, 1'b0, 1'b0);
      send(1'b1, 16'hFF00, 16'hFF00, 16'h0000);
      expect_op(8, 16'hFF95, 16'hFF17, 16'hFE00, 1, 1, 0, 1'b0, 1'b0);
      send(1'b0, 16'h0100, 16'h0000, 16'hFE00);
      wait_drain();

      // stalled output: latency counted with the accept edge as clock 1
      out_ready = 1'b0;
      expect_op(9, 16'h0100, 16'h0000, 16'h0000, 1, 1, 0, 1'b0, 1'b0);
      send(1'b0, 16'h0100, 16'h0000, 16'h0000);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk_int("latency_clocks", lat + 1, ITER_NUM + 3);
      hx = x_out; hy = y_out; ha = angle_out;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk_int("stall_stable", int'({out_valid, in_ready, x_out == hx, y_out == hy, angle_out == ha}),
                 int'(5'b10111));
      end
      out_ready = 1'b1;
      wait_drain();

      // back-to-back spacing with out_ready held high
      expect_op(10, 16'h00B5, 16'h00B5, 16'h00C9, 1, 1, 0, 1'b0, 1'b0);
      send(1'b0, 16'h0100, 16'h0000, 16'h00C9);
      t1 = t_acc;
      expect_op(11, 16'h0200, 16'h0000, 16'h010C, 2, 2, 1, 1'b0, 1'b0);
      send(1'b1, 16'h0100, 16'h01BB, 16'h0000);
      chk_int("b2b_spacing", int'((t_acc - t1) / 10), ITER_NUM + 4);
      wait_drain();

      // reset while iterating (i=5): operation discarded
      send(1'b0, 16'h0100, 16'h0000, 16'h00C9);
      repeat (6) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk_int("async_rst_out_valid", int'(out_valid), 0);
      chk_int("async_rst_outputs", int'({x_out, y_out, angle_out, sat_out, err_out}), 0);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      chk_int("post_rst_in_ready", int'(in_ready), 1);
      nval = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (out_valid) nval++;
      end
      chk_int("no_stale_out_valid", nval, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
